// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory pipeline stage: FSM states, access sizes,
// control-bit positions and pipeline-bus field offsets.
package mem_stage_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam int unsigned CtlLoad   = 4;
  localparam int unsigned CtlStore  = 3;
  localparam int unsigned CtlSizeHi = 2;
  localparam int unsigned CtlSizeLo = 1;
  localparam int unsigned CtlSext   = 0;

  localparam int unsigned PcLsb  = 96;
  localparam int unsigned Pc4Lsb = 64;
  localparam int unsigned AoLsb  = 32;
  localparam int unsigned RtLsb  = 0;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SizeHalf) && addr_lo[0]) || ((size == SizeWord) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and data replication, and load
// lane extraction with optional sign extension (little-endian lanes).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    case (size_i)
      SizeByte: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      end
      SizeHalf: begin
        be_o      = 4'b0011 << addr_lo_i;
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{sext_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, performs its data-memory
// access with a bounded ack wait, and flags alignment and bus errors.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cancel,
  input  logic         exe_over,
  input  logic         wb_allow_in,
  output logic         mem_allow_in,
  output logic         mem_over,
  input  logic [127:0] mem_in,
  input  logic [4:0]   mem_control,
  output logic [127:0] mem_out,
  output logic [31:0]  fwd_ao,
  output logic [31:0]  fwd_pc4,
  output logic         dm_req,
  output logic [3:0]   dm_we,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         adel,
  output logic         ades,
  output logic         bus_err,
  output logic [31:0]  bad_vaddr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [1:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic [127:0]    data_q, data_d;
  logic [4:0]      ctl_q, ctl_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     ld_data_q, ld_data_d;
  logic            bus_err_q, bus_err_d;

  logic [31:0] ao_q, rt_q, in_ao;
  logic        capture, in_mem_op, cur_mis, timeout_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;

  assign ao_q  = data_q[AoLsb +: 32];
  assign rt_q  = data_q[RtLsb +: 32];
  assign in_ao = mem_in[AoLsb +: 32];

  assign capture   = mem_allow_in & exe_over;
  // Only aligned loads/stores ever touch the bus; everything else completes in IDLE.
  assign in_mem_op = (mem_control[CtlLoad] | mem_control[CtlStore]) &
                     ~misaligned(mem_control[CtlSizeHi:CtlSizeLo], in_ao[1:0]);
  assign cur_mis     = misaligned(ctl_q[CtlSizeHi:CtlSizeLo], ao_q[1:0]);
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  mem_lane_align u_lane (
    .size_i    (ctl_q[CtlSizeHi:CtlSizeLo]),
    .addr_lo_i (ao_q[1:0]),
    .sext_i    (ctl_q[CtlSext]),
    .st_data_i (rt_q),
    .rdata_i   (dm_rdata),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ld_data_o (lane_ld)
  );

  assign mem_over     = valid_q & ((state_q == StIdle) | (state_q == StDone));
  assign mem_allow_in = (state_q != StDrain) & (~valid_q | (mem_over & wb_allow_in));
  assign dm_req       = (state_q == StAccess) | (state_q == StDrain);
  assign dm_we        = ((state_q == StAccess) && ctl_q[CtlStore] && !ctl_q[CtlLoad]) ?
                        lane_be : 4'b0000;
  assign dm_addr      = {ao_q[31:2], 2'b00};
  assign dm_wdata     = lane_wdata;

  assign adel      = valid_q & ctl_q[CtlLoad] & cur_mis;
  assign ades      = valid_q & ctl_q[CtlStore] & ~ctl_q[CtlLoad] & cur_mis;
  assign bus_err   = valid_q & bus_err_q;
  assign bad_vaddr = (adel | ades) ? ao_q : 32'd0;

  assign mem_out = {data_q[PcLsb +: 32], data_q[Pc4Lsb +: 32], ao_q, ld_data_q};
  assign fwd_ao  = ao_q;
  assign fwd_pc4 = data_q[Pc4Lsb +: 32];

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    ctl_d     = ctl_q;
    cnt_d     = '0;
    ld_data_d = ld_data_q;
    bus_err_d = bus_err_q;

    if (capture) begin
      data_d    = mem_in;
      ctl_d     = mem_control;
      ld_data_d = '0;
      bus_err_d = 1'b0;
    end

    if (cancel) begin
      valid_d = 1'b0;
    end else if (mem_allow_in) begin
      valid_d = exe_over;
    end

    case (state_q)
      StIdle: begin
        if (!cancel && capture && in_mem_op) state_d = StAccess;
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_ack || timeout_hit) begin
          // A cancel that coincides with completion needs no drain.
          state_d   = cancel ? StIdle : StDone;
          ld_data_d = (dm_ack && ctl_q[CtlLoad]) ? lane_ld : 32'd0;
          bus_err_d = ~dm_ack;
        end else if (cancel) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (dm_ack || timeout_hit) state_d = StIdle;
      end
      StDone: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (wb_allow_in) begin
          state_d = (capture && in_mem_op) ? StAccess : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ctl_q     <= '0;
      cnt_q     <= '0;
      ld_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ctl_q     <= ctl_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: retirements and bus requests are checked
// against expectations queued when each instruction is handed to the stage.
module tb_mem_stage;

  logic         clk;
  logic         reset, cancel, exe_over, wb_allow_in;
  logic         mem_allow_in, mem_over;
  logic [127:0] mem_in, mem_out;
  logic [4:0]   mem_control;
  logic [31:0]  fwd_ao, fwd_pc4;
  logic         dm_req, dm_ack;
  logic [3:0]   dm_we;
  logic [31:0]  dm_addr, dm_wdata, dm_rdata;
  logic         adel, ades, bus_err;
  logic [31:0]  bad_vaddr;

  typedef struct packed {
    logic [127:0] out;
    logic [2:0]   exc;
    logic [31:0]  bad;
  } ret_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_wd;
  } bus_t;

  ret_t        sb_q[$];
  bus_t        bus_q[$];
  int          n_checks, n_errors;
  int          ack_delay;
  logic [31:0] rdata_cfg;
  int          cyc, cap_cyc;

  mem_stage #(.TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .cancel       (cancel),
    .exe_over     (exe_over),
    .wb_allow_in  (wb_allow_in),
    .mem_allow_in (mem_allow_in),
    .mem_over     (mem_over),
    .mem_in       (mem_in),
    .mem_control  (mem_control),
    .mem_out      (mem_out),
    .fwd_ao       (fwd_ao),
    .fwd_pc4      (fwd_pc4),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_ack       (dm_ack),
    .dm_rdata     (dm_rdata),
    .adel         (adel),
    .ades         (ades),
    .bus_err      (bus_err),
    .bad_vaddr    (bad_vaddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles (negative = never).
  initial begin : responder
    int   waits;
    bus_t b;
    waits    = 0;
    dm_ack   = 1'b0;
    dm_rdata = '0;
    forever begin
      @(negedge clk);
      dm_rdata = rdata_cfg;
      if (reset) begin
        dm_ack = 1'b0;
        waits  = 0;
      end else if (dm_req) begin
        if (waits == 0) begin
          if (bus_q.size() == 0) begin
            check("req_unexpected", 128'(dm_req), 128'(0));
          end else begin
            b = bus_q.pop_front();
            check("dm_we", 128'(dm_we), 128'(b.we));
            check("dm_addr", 128'(dm_addr), 128'(b.addr));
            if (b.chk_wd) check("dm_wdata", 128'(dm_wdata), 128'(b.wd));
          end
        end
        if (ack_delay >= 0 && waits == ack_delay) begin
          dm_ack = 1'b1;
          waits  = 0;
        end else begin
          dm_ack = 1'b0;
          waits++;
        end
      end else begin
        dm_ack = 1'b0;
        waits  = 0;
        check("we_idle", 128'(dm_we), 128'(0));
      end
    end
  end

  initial begin : monitor
    ret_t r;
    forever begin
      @(negedge clk);
      if (!reset && mem_over && wb_allow_in) begin
        if (sb_q.size() == 0) begin
          check("retire_unexpected", 128'(mem_over), 128'(0));
        end else begin
          r = sb_q.pop_front();
          check("mem_out", mem_out, r.out);
          check("exc", 128'({adel, ades, bus_err}), 128'(r.exc));
          check("bad_vaddr", 128'(bad_vaddr), 128'(r.bad));
        end
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] ao, input logic [31:0] rt,
                      input logic [4:0] ctl, input logic [31:0] exp_ld,
                      input logic [2:0] exp_exc, input logic [31:0] exp_bad,
                      input logic bus, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                      input logic chk_wd, input logic retire);
    logic got;
    got         = 1'b0;
    mem_in      = {pc, pc + 32'd4, ao, rt};
    mem_control = ctl;
    exe_over    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_allow_in) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("send_stall", 128'(mem_allow_in), 128'(1));
      exe_over = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exe_over = 1'b0;
    cap_cyc  = cyc;
    if (retire) sb_q.push_back(ret_t'{out: {pc, pc + 32'd4, ao, exp_ld}, exc: exp_exc,
                                      bad: exp_bad});
    if (bus) bus_q.push_back(bus_t'{we: exp_we, addr: {ao[31:2], 2'b00}, wd: exp_wd,
                                    chk_wd: chk_wd});
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && bus_q.size() == 0) break;
      @(negedge clk);
    end
    check("queues_empty", 128'(sb_q.size() + bus_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int caps[4];
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    cancel      = 1'b0;
    exe_over    = 1'b1;
    wb_allow_in = 1'b1;
    mem_in      = {4{32'h1111_2222}};
    mem_control = 5'b10100;
    ack_delay   = 0;
    rdata_cfg   = '0;

    // Reset with an instruction offered: nothing may be captured.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_over", 128'(mem_over), 128'(0));
    check("rst_dm_req", 128'(dm_req), 128'(0));
    check("rst_dm_we", 128'(dm_we), 128'(0));
    check("rst_exc", 128'({adel, ades, bus_err}), 128'(0));
    check("rst_allow", 128'(mem_allow_in), 128'(1));
    check("rst_mem_out", mem_out, 128'(0));
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exe_over = 1'b0;

    // Non-memory op whose ao would be misaligned for a word: no exception, zero latency.
    send(32'h1000, 32'h1233, 32'h55, 5'b00100, 32'h0, 3'b000, 32'h0, 1'b0, 4'h0, 32'h0,
         1'b0, 1'b1);
    @(negedge clk);
    check("nonmem_over", 128'(mem_over), 128'(1));
    drain();

    // Word store, ack on third request cycle; completion the cycle after ack.
    ack_delay = 2;
    send(32'h2000, 32'h100, 32'hDEAD_BEEF, 5'b01100, 32'h0, 3'b000, 32'h0, 1'b1, 4'b1111,
         32'hDEAD_BEEF, 1'b1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("st_wait_over", 128'(mem_over), 128'(0));
      check("st_wait_req", 128'(dm_req), 128'(1));
    end
    @(negedge clk);
    check("st_over_after_ack", 128'(mem_over), 128'(1));
    drain();

    // Loads: byte signed/unsigned, half signed (upper lane), half unsigned (lower lane).
    ack_delay = 0;
    rdata_cfg = 32'h80FF_FFFF;
    send(32'h2100, 32'h103, 32'h0, 5'b10001, 32'hFFFF_FF80, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();
    send(32'h2104, 32'h103, 32'h0, 5'b10000, 32'h0000_0080, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();
    rdata_cfg = 32'h8001_1234;
    send(32'h2108, 32'h102, 32'h0, 5'b10011, 32'hFFFF_8001, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();
    send(32'h210C, 32'h100, 32'h0, 5'b10010, 32'h0000_1234, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();

    // Byte and half stores: enables shifted by offset, data replicated.
    send(32'h2200, 32'h201, 32'h1234_56AB, 5'b01000, 32'h0, 3'b000, 32'h0, 1'b1, 4'b0010,
         32'hABAB_ABAB, 1'b1, 1'b1);
    drain();
    send(32'h2204, 32'h302, 32'h1234_CDEF, 5'b01010, 32'h0, 3'b000, 32'h0, 1'b1, 4'b1100,
         32'hCDEF_CDEF, 1'b1, 1'b1);
    drain();

    // Misaligned half load held while write-back stalls.
    wb_allow_in = 1'b0;
    send(32'h3000, 32'h101, 32'h0, 5'b10010, 32'h0, 3'b100, 32'h101, 1'b0, 4'h0, 32'h0,
         1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("adel_held", 128'(adel), 128'(1));
      check("adel_bad_vaddr", 128'(bad_vaddr), 128'(32'h101));
      check("adel_over", 128'(mem_over), 128'(1));
      check("adel_no_req", 128'(dm_req), 128'(0));
    end
    @(posedge clk);
    #1;
    wb_allow_in = 1'b1;
    drain();

    // Misaligned word store.
    send(32'h3004, 32'h102, 32'h77, 5'b01100, 32'h0, 3'b010, 32'h102, 1'b0, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();

    // Cancel in second ACCESS cycle; ack arrives three cycles later.
    ack_delay = 4;
    send(32'h5000, 32'h500, 32'h0, 5'b10100, 32'h0, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b0);
    @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      check("drain_allow", 128'(mem_allow_in), 128'(0));
      check("drain_over", 128'(mem_over), 128'(0));
      n++;
    end
    check("drain_cycles", 128'(n), 128'(3));
    check("drain_allow_after", 128'(mem_allow_in), 128'(1));
    drain();

    // No ack: bus error after 15 request cycles.
    ack_delay = -1;
    rdata_cfg = 32'hFFFF_FFFF;
    send(32'h6000, 32'h400, 32'h0, 5'b10100, 32'h0, 3'b001, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!dm_req) break;
      n++;
    end
    check("timeout_req_cycles", 128'(n), 128'(15));
    check("timeout_over", 128'(mem_over), 128'(1));
    check("timeout_bus_err", 128'(bus_err), 128'(1));
    drain();

    // Back-to-back word stores with immediate ack: one every two cycles.
    ack_delay = 0;
    for (int k = 0; k < 4; k++) begin
      send(32'h7000 + 32'(4 * k), 32'h700 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 5'b01100,
           32'h0, 3'b000, 32'h0, 1'b1, 4'b1111, 32'h1111_1111 * 32'(k + 1), 1'b1, 1'b1);
      caps[k] = cap_cyc;
    end
    for (int k = 1; k < 4; k++) begin
      check("b2b_spacing", 128'(caps[k] - caps[k-1]), 128'(2));
    end
    drain();

    // Reset mid-ACCESS: request drops at once, no drain.
    ack_delay = -1;
    send(32'h8000, 32'h600, 32'h0, 5'b10100, 32'h0, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_req", 128'(dm_req), 128'(0));
    check("rst_mid_over", 128'(mem_over), 128'(0));
    check("rst_mid_allow", 128'(mem_allow_in), 128'(1));
    check("rst_mid_bus_err", 128'(bus_err), 128'(0));
    @(posedge clk);
    #1;

    // Normal word load after the mid-access reset.
    ack_delay = 1;
    rdata_cfg = 32'hCAFE_F00D;
    send(32'h9000, 32'h800, 32'h0, 5'b10100, 32'hCAFE_F00D, 3'b000, 32'h0, 1'b1, 4'h0, 32'h0,
         1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum dm_ack wait cycles before a bus error.
REQ-002 SHALL have port clk  in  1  clock; all state on posedge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cancel  in  1  exception/flush kill of the stage contents.
REQ-005 SHALL have port exe_over  in  1  upstream stage holds a completed instruction.
REQ-006 SHALL have port wb_allow_in  in  1  downstream write-back stage can accept.
REQ-007 SHALL have port mem_allow_in  out  1  stage can accept this cycle.
REQ-008 SHALL have port mem_over  out  1  stage holds a completed instruction.
REQ-009 SHALL have port mem_in  in  128  {pc[127:96], pc4[95:64], ao[63:32], rt[31:0]}.
REQ-010 SHALL have port mem_control  in  5  [4] load, [3] store, [2:1] size (00 byte, 01 half, 10 word), [0] sign-extend load.
REQ-011 SHALL have port mem_out  out  128  {pc, pc4, ao, ld_data}.
REQ-012 SHALL have ports fwd_ao  out  32 and fwd_pc4  out  32, the latched ao/pc4 for upstream forwarding.
REQ-013 SHALL have data-memory ports dm_req out 1, dm_we out 4, dm_addr out 32 (word-aligned), dm_wdata out 32, dm_ack in 1, dm_rdata in 32.
REQ-014 SHALL have exception outputs adel out 1, ades out 1, bus_err out 1, bad_vaddr out 32.

Function
REQ-015 SHALL latch mem_in and mem_control when mem_allow_in & exe_over; valid SHALL clear when mem_allow_in & ~exe_over.
REQ-016 SHALL assert mem_allow_in = ~valid | (mem_over & wb_allow_in).
REQ-017 SHALL use FSM states IDLE, ACCESS, DONE, DRAIN.
REQ-018 Non-memory instruction: SHALL stay IDLE; mem_over SHALL equal valid (zero added latency).
REQ-019 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0): SHALL raise adel (load) or ades (store) and set bad_vaddr=ao, with no dm_req issued; mem_over SHALL equal valid.
REQ-020 Aligned load/store: SHALL go IDLE->ACCESS the cycle after capture; dm_req SHALL be held high in ACCESS until dm_ack.
REQ-021 On dm_ack in ACCESS: SHALL register lane-selected ld_data and go DONE; mem_over SHALL be 1 in DONE.
REQ-022 DONE->IDLE when wb_allow_in, or directly to ACCESS when a new aligned memory op is captured that same cycle.
REQ-023 Store: dm_we SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word); dm_wdata SHALL replicate rt[7:0] x4 or rt[15:0] x2; dm_we SHALL be 0 on loads and outside ACCESS.
REQ-024 Load: SHALL select byte/half by addr[1:0] and sign-extend when mem_control[0]=1, zero-extend otherwise.
REQ-025 A wait counter SHALL count ACCESS cycles; at TIMEOUT without dm_ack SHALL set bus_err=1, ld_data=0, and go DONE.
REQ-026 cancel in ACCESS SHALL clear valid and go DRAIN, keeping dm_req high; DRAIN SHALL discard dm_rdata and return to IDLE on dm_ack or timeout; mem_allow_in SHALL be 0 in DRAIN.
REQ-027 cancel in IDLE/DONE SHALL clear valid and return to IDLE the next cycle.
REQ-028 Exception outputs SHALL be qualified by valid and held until the instruction leaves.

Reset
REQ-029 reset SHALL force IDLE, valid=0, counter=0; mem_over, dm_req, dm_we, adel, ades, bus_err SHALL read 0 the cycle after reset.
REQ-030 reset SHALL take priority over cancel and capture, including mid-ACCESS (no drain).

Structure
REQ-031 State encodings, size codes and mem_control bit positions SHALL live in a shared package with the pipeline field offsets.
REQ-032 Byte-enable/store-replication and load-extract logic SHALL be one sub-module, mem_lane_align.

Verification
REQ-033 Word store at ao=0x100, rt=0xDEADBEEF, ack after 2 cycles -> dm_we=1111, dm_addr=0x100, mem_over on the cycle after ack.
REQ-034 Signed byte load at ao=0x103, dm_rdata=0x80FF_FF_FF -> ld_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Half load at ao=0x101 -> adel=1, bad_vaddr=0x101, dm_req never asserted.
REQ-036 cancel in second ACCESS cycle, ack 3 cycles later -> DRAIN, mem_allow_in=0 until ack, no mem_over.
REQ-037 No dm_ack for 15 cycles -> bus_err=1, mem_over=1, ld_data=0.
REQ-038 Back-to-back stores with wb_allow_in=1, ack same cycle as req -> DONE->ACCESS, one store completed every 2 cycles.
